// File: rtl/di_hazard_stall_unit.sv
// Decode-stage hazard detection and stall controller with saturating stall/flush counters.
// Covers the beq/load cases the decode forwarding paths cannot resolve in time.
module di_hazard_stall_unit #(
   parameter int unsigned COUNTER_WIDTH = 16,
   parameter logic [5:0]  BEQ_OP        = 6'b000100,
   parameter logic [5:0]  RTYPE_OP      = 6'b000000,
   parameter logic [5:0]  SW_OP         = 6'b101011,
   parameter logic [5:0]  J_OP          = 6'b000010
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [4:0]               IFIDReadReg1,
   input  logic [4:0]               IFIDReadReg2,
   input  logic [5:0]               operation,
   input  logic                     IDEXWriteSignal,
   input  logic                     IDEXMemRead,
   input  logic [4:0]               IDEXWriteReg,
   input  logic                     EXMEWriteSignal,
   input  logic                     EXMEMemRead,
   input  logic [4:0]               EXMEWriteReg,
   input  logic                     branchTaken,
   output logic                     pcWriteEnable,
   output logic                     IFIDWriteEnable,
   output logic                     IDEXBubble,
   output logic                     IFIDFlush,
   output logic [COUNTER_WIDTH-1:0] stallCycles,
   output logic [COUNTER_WIDTH-1:0] flushCount
);

   logic [1:0]               stallRemainingReg;
   logic [1:0]               stallRemainingNext;
   logic [COUNTER_WIDTH-1:0] stallCyclesReg;
   logic [COUNTER_WIDTH-1:0] stallCyclesNext;
   logic [COUNTER_WIDTH-1:0] flushCountReg;
   logic [COUNTER_WIDTH-1:0] flushCountNext;

   logic       usesRs;
   logic       usesRt;
   logic       isBeq;
   logic [4:0] srcReg [2];
   logic [1:0] srcUsed;
   logic [1:0] idexMatch;
   logic [1:0] exmemMatch;
   logic       idexHit;
   logic       exmemHit;
   logic       hazA;
   logic       hazB;
   logic       hazC;
   logic       hazD;
   logic [1:0] need;
   logic       stall;
   logic       flush;

   assign usesRs = (operation != J_OP);
   assign usesRt = (operation == RTYPE_OP) || (operation == BEQ_OP) || (operation == SW_OP);
   assign isBeq  = (operation == BEQ_OP);

   assign srcReg[0]  = IFIDReadReg1;
   assign srcReg[1]  = IFIDReadReg2;
   assign srcUsed[0] = usesRs;
   assign srcUsed[1] = usesRt;

   // Register 0 is hardwired, so it can never be a true dependency.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : gSrcMatch
         assign idexMatch[gi]  = srcUsed[gi] && (srcReg[gi] != 5'd0) && (srcReg[gi] == IDEXWriteReg);
         assign exmemMatch[gi] = srcUsed[gi] && (srcReg[gi] != 5'd0) && (srcReg[gi] == EXMEWriteReg);
      end
   endgenerate

   assign idexHit  = |idexMatch;
   assign exmemHit = |exmemMatch;

   assign hazA = IDEXMemRead  && IDEXWriteSignal && idexHit  &&  isBeq;
   assign hazB = IDEXMemRead  && IDEXWriteSignal && idexHit  && !isBeq;
   assign hazC = !IDEXMemRead && IDEXWriteSignal && idexHit  &&  isBeq;
   assign hazD = EXMEMemRead  && EXMEWriteSignal && exmemHit &&  isBeq;

   // Hazard inputs are only trusted when no stall is already in progress.
   always_comb begin
      need = 2'd0;
      if (stallRemainingReg == 2'd0) begin
         if (hazA) begin
            need = 2'd2;
         end else if (hazB || hazC || hazD) begin
            need = 2'd1;
         end
      end
   end

   assign stall = (stallRemainingReg != 2'd0) || (need != 2'd0);
   assign flush = branchTaken && !stall;

   always_comb begin
      stallRemainingNext = 2'd0;
      if (stallRemainingReg != 2'd0) begin
         stallRemainingNext = stallRemainingReg - 2'd1;
      end else if (need != 2'd0) begin
         stallRemainingNext = need - 2'd1;
      end
   end

   always_comb begin
      stallCyclesNext = stallCyclesReg;
      flushCountNext  = flushCountReg;
      if (stall && (stallCyclesReg != {COUNTER_WIDTH{1'b1}})) begin
         stallCyclesNext = stallCyclesReg + COUNTER_WIDTH'(1);
      end
      if (flush && (flushCountReg != {COUNTER_WIDTH{1'b1}})) begin
         flushCountNext = flushCountReg + COUNTER_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallRemainingReg <= 2'd0;
         stallCyclesReg    <= '0;
         flushCountReg     <= '0;
      end else begin
         stallRemainingReg <= stallRemainingNext;
         stallCyclesReg    <= stallCyclesNext;
         flushCountReg     <= flushCountNext;
      end
   end

   // Reset forces the pipeline controls to their free-running values at once.
   assign pcWriteEnable   = reset || !stall;
   assign IFIDWriteEnable = reset || !stall;
   assign IDEXBubble      = !reset && stall;
   assign IFIDFlush       = !reset && flush;
   assign stallCycles     = stallCyclesReg;
   assign flushCount      = flushCountReg;

endmodule

// File: tb/tb_di_hazard_stall_unit.sv
// Bench for di_hazard_stall_unit: table vectors, directed multi-cycle sequences and a
// randomized run checked against a stall-window reference model.
module tb_di_hazard_stall_unit;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_LW   = 6'b100011;

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [5:0] op;
      logic       idexW;
      logic       idexMR;
      logic [4:0] idexWR;
      logic       exW;
      logic       exMR;
      logic [4:0] exWR;
      logic       br;
   } vecIn_t;

   typedef struct {
      vecIn_t in;
      logic   expStall;
      logic   expFlush;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  IFIDReadReg1 = '0, IFIDReadReg2 = '0, IDEXWriteReg = '0, EXMEWriteReg = '0;
   logic [5:0]  operation = '0;
   logic        IDEXWriteSignal = 1'b0, IDEXMemRead = 1'b0, EXMEWriteSignal = 1'b0, EXMEMemRead = 1'b0;
   logic        branchTaken = 1'b0;
   logic        pcWriteEnable, IFIDWriteEnable, IDEXBubble, IFIDFlush;
   logic [15:0] stallCycles, flushCount;
   logic        pcWe4, ifidWe4, bubble4, flush4;
   logic [3:0]  stallCycles4, flushCount4;

   int errors = 0;
   int checks = 0;

   // reference model state
   int cyc = 0;
   int stallUntil = 0;
   int mStall16 = 0, mFlush16 = 0, mStall4 = 0, mFlush4 = 0;

   always #5 clk = ~clk;

   di_hazard_stall_unit dut (
      .clk(clk), .reset(reset),
      .IFIDReadReg1(IFIDReadReg1), .IFIDReadReg2(IFIDReadReg2), .operation(operation),
      .IDEXWriteSignal(IDEXWriteSignal), .IDEXMemRead(IDEXMemRead), .IDEXWriteReg(IDEXWriteReg),
      .EXMEWriteSignal(EXMEWriteSignal), .EXMEMemRead(EXMEMemRead), .EXMEWriteReg(EXMEWriteReg),
      .branchTaken(branchTaken),
      .pcWriteEnable(pcWriteEnable), .IFIDWriteEnable(IFIDWriteEnable), .IDEXBubble(IDEXBubble),
      .IFIDFlush(IFIDFlush), .stallCycles(stallCycles), .flushCount(flushCount)
   );

   di_hazard_stall_unit #(.COUNTER_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset),
      .IFIDReadReg1(IFIDReadReg1), .IFIDReadReg2(IFIDReadReg2), .operation(operation),
      .IDEXWriteSignal(IDEXWriteSignal), .IDEXMemRead(IDEXMemRead), .IDEXWriteReg(IDEXWriteReg),
      .EXMEWriteSignal(EXMEWriteSignal), .EXMEMemRead(EXMEMemRead), .EXMEWriteReg(EXMEWriteReg),
      .branchTaken(branchTaken),
      .pcWriteEnable(pcWe4), .IFIDWriteEnable(ifidWe4), .IDEXBubble(bubble4),
      .IFIDFlush(flush4), .stallCycles(stallCycles4), .flushCount(flushCount4)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vecIn_t mk(input logic [5:0] op, input int rs, input int rt,
                                 input int idexW, input int idexMR, input int idexWR,
                                 input int exW, input int exMR, input int exWR, input int br);
      vecIn_t v;
      v.op = op; v.rs = 5'(rs); v.rt = 5'(rt);
      v.idexW = 1'(idexW); v.idexMR = 1'(idexMR); v.idexWR = 5'(idexWR);
      v.exW = 1'(exW); v.exMR = 1'(exMR); v.exWR = 5'(exWR); v.br = 1'(br);
      return v;
   endfunction

   // Stall cycles a fresh ID instruction requires, straight from the hazard rules.
   function automatic int modelNeed(input vecIn_t v);
      bit readsRs, readsRt, beq, onIdex, onExmem;
      int n;
      readsRs = (v.op != OP_J);
      readsRt = (v.op == OP_R) || (v.op == OP_BEQ) || (v.op == OP_SW);
      beq     = (v.op == OP_BEQ);
      onIdex  = (readsRs && v.rs != 0 && v.rs == v.idexWR) || (readsRt && v.rt != 0 && v.rt == v.idexWR);
      onExmem = (readsRs && v.rs != 0 && v.rs == v.exWR)  || (readsRt && v.rt != 0 && v.rt == v.exWR);
      n = 0;
      if (v.idexW && onIdex) n = v.idexMR ? (beq ? 2 : 1) : (beq ? 1 : 0);
      if (v.exW && v.exMR && onExmem && beq && n < 1) n = 1;
      return n;
   endfunction

   // One clock cycle: drive at negedge, compare DUT with the model, then advance the model.
   task automatic cycle(input vecIn_t v, input bit rst, input bit useExp,
                        input bit eStall, input bit eFlush);
      bit inWindow, mStall, mFlush;
      int n;
      @(negedge clk);
      reset = rst;
      IFIDReadReg1 = v.rs; IFIDReadReg2 = v.rt; operation = v.op;
      IDEXWriteSignal = v.idexW; IDEXMemRead = v.idexMR; IDEXWriteReg = v.idexWR;
      EXMEWriteSignal = v.exW; EXMEMemRead = v.exMR; EXMEWriteReg = v.exWR;
      branchTaken = v.br;
      #1;
      if (rst) begin
         stallUntil = 0;
         mStall16 = 0; mFlush16 = 0; mStall4 = 0; mFlush4 = 0;
         inWindow = 0; n = 0; mStall = 0; mFlush = 0;
      end else begin
         inWindow = (cyc < stallUntil);
         n = inWindow ? 0 : modelNeed(v);
         mStall = inWindow || (n > 0);
         mFlush = v.br && !mStall;
      end
      chk("pcWriteEnable", int'(pcWriteEnable), int'(!mStall));
      chk("IFIDWriteEnable", int'(IFIDWriteEnable), int'(!mStall));
      chk("IDEXBubble", int'(IDEXBubble), int'(mStall));
      chk("IFIDFlush", int'(IFIDFlush), int'(mFlush));
      chk("stallCycles", int'(stallCycles), mStall16);
      chk("flushCount", int'(flushCount), mFlush16);
      chk("stallCycles4", int'(stallCycles4), mStall4);
      chk("flushCount4", int'(flushCount4), mFlush4);
      if (useExp) begin
         chk("tableStall", int'(IDEXBubble), int'(eStall));
         chk("tableFlush", int'(IFIDFlush), int'(eFlush));
      end
      $display("cyc=%0d rst=%0b op=%0h rs=%0d rt=%0d stall=%0b flush=%0b sc=%0d fc=%0d sc4=%0d",
               cyc, rst, v.op, v.rs, v.rt, IDEXBubble, IFIDFlush, stallCycles, flushCount, stallCycles4);
      if (!rst) begin
         if (!inWindow && n > 0) stallUntil = cyc + n;
         if (mStall) begin
            if (mStall16 < 65535) mStall16++;
            if (mStall4 < 15) mStall4++;
         end
         if (mFlush) begin
            if (mFlush16 < 65535) mFlush16++;
            if (mFlush4 < 15) mFlush4++;
         end
      end
      cyc++;
   endtask

   vec_t   tbl [13];
   vecIn_t idle, hA, hB;

   initial begin
      idle = mk(OP_R, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      hA   = mk(OP_BEQ, 12, 9, 1, 1, 9, 0, 0, 0, 0);
      hB   = mk(OP_R, 5, 6, 1, 1, 5, 0, 0, 0, 0);

      tbl[0]  = '{mk(OP_R,    1, 2, 1, 0, 3, 0, 0, 0, 0), 1'b0, 1'b0};
      tbl[1]  = '{mk(OP_R,    5, 6, 1, 1, 5, 0, 0, 0, 0), 1'b1, 1'b0};
      tbl[2]  = '{mk(OP_R,    0, 6, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0};
      tbl[3]  = '{mk(OP_BEQ,  7, 3, 1, 0, 7, 0, 0, 0, 0), 1'b1, 1'b0};
      tbl[4]  = '{mk(OP_ADDI, 7, 9, 1, 0, 7, 0, 0, 0, 0), 1'b0, 1'b0};
      tbl[5]  = '{mk(OP_BEQ,  4, 4, 0, 0, 0, 1, 1, 4, 1), 1'b1, 1'b0};
      tbl[6]  = '{mk(OP_BEQ,  4, 4, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b1};
      tbl[7]  = '{mk(OP_J,    5, 5, 1, 1, 5, 0, 0, 0, 0), 1'b0, 1'b0};
      tbl[8]  = '{mk(OP_ADDI, 1, 5, 1, 1, 5, 0, 0, 0, 0), 1'b0, 1'b0};
      tbl[9]  = '{mk(OP_SW,   1, 5, 1, 1, 5, 0, 0, 0, 0), 1'b1, 1'b0};
      tbl[10] = '{mk(OP_R,    4, 1, 0, 0, 0, 1, 1, 4, 0), 1'b0, 1'b0};
      tbl[11] = '{mk(OP_BEQ,  4, 1, 0, 0, 0, 1, 0, 4, 0), 1'b0, 1'b0};
      tbl[12] = '{mk(OP_BEQ,  4, 1, 0, 1, 4, 0, 0, 0, 0), 1'b0, 1'b0};

      // reset state, with a hazard present on the inputs
      cycle(hA, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("resetStallCycles", int'(stallCycles), 0);

      // single-cycle vectors, each from a freshly reset state
      for (int i = 0; i < 13; i++) begin
         cycle(idle, 1'b1, 1'b0, 1'b0, 1'b0);
         cycle(tbl[i].in, 1'b0, 1'b1, tbl[i].expStall, tbl[i].expFlush);
      end

      // load feeding beq: two stall cycles even when ID/EX becomes a bubble
      cycle(idle, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(hA, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(mk(OP_BEQ, 12, 9, 0, 0, 0, 1, 1, 9, 0), 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(mk(OP_BEQ, 12, 9, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("seqA_stallCycles", int'(stallCycles), 2);

      // branch during a stall is ignored, honoured the cycle after
      cycle(idle, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(mk(OP_BEQ, 4, 4, 0, 0, 0, 1, 1, 4, 1), 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(mk(OP_BEQ, 4, 4, 0, 0, 0, 0, 0, 0, 1), 1'b0, 1'b1, 1'b0, 1'b1);
      cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("seqD_flushCount", int'(flushCount), 1);

      // asynchronous reset in the middle of a two-cycle stall
      cycle(idle, 1'b1, 1'b0, 1'b0, 1'b0);
      cycle(hA, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("midStallBubble", int'(IDEXBubble), 1);
      reset = 1'b1;
      #1;
      chk("asyncRstPcWe", int'(pcWriteEnable), 1);
      chk("asyncRstBubble", int'(IDEXBubble), 0);
      chk("asyncRstStallCycles", int'(stallCycles), 0);
      stallUntil = 0;
      mStall16 = 0; mFlush16 = 0; mStall4 = 0; mFlush4 = 0;
      cyc++;
      cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0);
      cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0);

      // saturation of the 4-bit counter under a persistent hazard
      cycle(idle, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(hB, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle(idle, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat4_stallCycles", int'(stallCycles4), 15);
      chk("sat16_stallCycles", int'(stallCycles), 20);

      // randomized traffic on a small register set so hazards are frequent
      for (int i = 0; i < 400; i++) begin
         vecIn_t r;
         logic [5:0] ops [6];
         ops[0] = OP_R; ops[1] = OP_BEQ; ops[2] = OP_SW;
         ops[3] = OP_J; ops[4] = OP_ADDI; ops[5] = OP_LW;
         r = mk(ops[$urandom_range(5)], $urandom_range(3), $urandom_range(3),
                $urandom_range(1), $urandom_range(1), $urandom_range(3),
                $urandom_range(1), $urandom_range(1), $urandom_range(3),
                $urandom_range(1));
         cycle(r, ($urandom_range(39) == 0), 1'b0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/di_hazard_stall_unit.md
Name: di_hazard_stall_unit

Overview:
Decode-stage hazard detection and stall controller; the counterpart of the decode-stage forwarding unit. The forwarding unit resolves beq operands from EX/MEM and MEM/WB. This block stalls the cases forwarding cannot resolve: a result still in ID/EX, or load data not yet returned. It drives the PC and IF/ID write enables, the ID/EX bubble and the IF/ID flush on taken branches. It also keeps saturating stall and flush event counters.

Parameters:
COUNTER_WIDTH, 16, width of stallCycles and flushCount
BEQ_OP, 6'b000100, beq opcode
RTYPE_OP, 6'b000000, R-type opcode (reads rs and rt)
SW_OP, 6'b101011, sw opcode (reads rs and rt)
J_OP, 6'b000010, jump opcode (reads no registers)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high
IFIDReadReg1  input  5  rs of the instruction in ID
IFIDReadReg2  input  5  rt of the instruction in ID
operation  input  6  opcode of the instruction in ID
IDEXWriteSignal  input  1  ID/EX instruction writes the register file
IDEXMemRead  input  1  ID/EX instruction is a load
IDEXWriteReg  input  5  ID/EX destination register
EXMEWriteSignal  input  1  EX/MEM instruction writes the register file
EXMEMemRead  input  1  EX/MEM instruction is a load
EXMEWriteReg  input  5  EX/MEM destination register
branchTaken  input  1  beq in ID resolved taken this cycle
pcWriteEnable  output  1  0 freezes the PC
IFIDWriteEnable  output  1  0 freezes IF/ID
IDEXBubble  output  1  1 zeroes ID/EX control signals
IFIDFlush  output  1  1 clears IF/ID at the next edge
stallCycles  output  COUNTER_WIDTH  saturating count of stalled cycles
flushCount  output  COUNTER_WIDTH  saturating count of flushes

Behaviour:
- Operand use:
  - usesRs = (operation != J_OP).
  - usesRt = operation in {RTYPE_OP, BEQ_OP, SW_OP}.
  - A match requires the source to be used, the register to be nonzero, and equal register numbers.
- Hazard classes, evaluated only when the stall state is 0:
  - A: IDEXMemRead & IDEXWriteSignal & match on IDEXWriteReg & operation==BEQ_OP. Need = 2.
  - B: IDEXMemRead & IDEXWriteSignal & match on IDEXWriteReg & operation!=BEQ_OP. Need = 1.
  - C: !IDEXMemRead & IDEXWriteSignal & match on IDEXWriteReg & operation==BEQ_OP. Need = 1.
  - D: EXMEMemRead & EXMEWriteSignal & match on EXMEWriteReg & operation==BEQ_OP. Need = 1.
  - Need is the maximum over all asserted classes.
- State: 2-bit stallRemaining, reset to 0.
  - stall = (stallRemaining != 0) | (need != 0). This is Mealy: a stall asserts in the same cycle the hazard is seen.
  - Next state:
    - stallRemaining != 0: decrement by 1. All hazard inputs are ignored.
    - stallRemaining == 0 and need != 0: load need-1.
    - Otherwise hold at 0.
- Stall outputs: pcWriteEnable = !stall, IFIDWriteEnable = !stall, IDEXBubble = stall.
- Flush:
  - IFIDFlush = branchTaken & !stall. During a stall the beq operands are stale, so branchTaken is ignored.
  - Flush and stall are never asserted together.
- Counters, updated on the rising edge:
  - stallCycles += 1 on each cycle with stall = 1.
  - flushCount += 1 on each cycle with IFIDFlush = 1.
  - Both saturate at all-ones; no wrap.
- Reset, asynchronous and taking effect immediately, including mid-stall:
  - stallRemaining = 0, stallCycles = 0, flushCount = 0.
  - While reset is high: pcWriteEnable = 1, IFIDWriteEnable = 1, IDEXBubble = 0, IFIDFlush = 0, regardless of other inputs.
- Register 0 never causes a hazard.
- Simultaneous rs and rt hazards count once; need is not summed.
- Latency: outputs are combinational from the current state and inputs. State and counters update on the next rising edge.

Test Plan:
1. lw $9 in ID/EX (IDEXMemRead=1, IDEXWriteSignal=1, IDEXWriteReg=9); ID holds beq $12,$9 -> stall in cycles 0 and 1 even if the ID/EX inputs go to bubble values in cycle 1. Cycle 2 unstalled; stallCycles=2.
2. lw $5 in ID/EX; ID holds R-type reading rs=5 -> exactly one stall cycle, IDEXBubble=1 for 1 cycle. Same case with IDEXWriteReg=0 and rs=0 -> no stall.
3. ALU write to $7 in ID/EX (MemRead=0); ID holds beq $7,$3 -> 1 stall cycle. Same producer with ID holding addi reading rs=7 -> no stall (EX forwarding handles it).
4. lw $4 in EX/MEM; ID holds beq $4,$4 -> 1 stall cycle. branchTaken=1 during that cycle -> IFIDFlush=0. branchTaken=1 in the next cycle -> IFIDFlush=1, flushCount=1.
5. Start a class-A stall, then assert reset after 1 cycle -> outputs immediately pcWriteEnable=1, IDEXBubble=0, counters 0. After release with no hazard -> no stall.
6. With COUNTER_WIDTH=4, hold a stall for 20 cycles -> stallCycles stops at 15.
